// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Generates PC / IF/ID / ID/EX enables and flushes for load-use hazards,
// taken branches, instruction-fetch wait states and multi-cycle mul/div.
// All control outputs are combinational from state, cnt and the current inputs.
// Optional build macro: HAZARD_STALL_CNT_EN enables the 32-bit stall counter
// on stall_count; without it stall_count is tied to zero.
//
// Handshake note: imem_ready is a plain per-cycle valid from instruction
// memory; there is no ready back-pressure, a missing fetch is replaced by a
// bubble (IF/ID flushed) while the PC holds its value.

module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_hold,
  output logic        md_done,
  output logic [31:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Cycles remaining after the start cycle before md_done, minus one.
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;

  // A load in EX whose destination is read by the instruction in ID; r0 never hazards.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rt)) ||
                (id_uses_rt && (id_rt == ex_rt)));
  end

  // State and mul/div counter register; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a taken branch squashes the mul/div start in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (!ex_branch_taken && ex_md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: reset override, then MD_BUSY, then RUN priority chain.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    md_done     = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_md_start) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt != '0) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
          end else begin
            md_done = 1'b1;
          end
        end
        default: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count every non-reset cycle in which the PC is held; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
    end else if (!pc_write) begin
      stall_cnt_q <= stall_cnt_q + 32'h1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MD_LATENCY=4).
// Outputs are compared as a packed vector
// {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, md_done}.

module tb_pipeline_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 4;

  // Expected output patterns
  localparam logic [5:0] O_DEF  = 6'b110000;
  localparam logic [5:0] O_RST  = 6'b001100;
  localparam logic [5:0] O_MDH  = 6'b000010;
  localparam logic [5:0] O_LU   = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111100;
  localparam logic [5:0] O_IMW  = 6'b011000;
  localparam logic [5:0] O_DONE = 6'b110001;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       md;
    logic       imr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        imem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_hold;
  logic        md_done;
  logic [31:0] stall_count;

  int          checks_total;
  int          checks_passed;
  logic [31:0] exp_stalls;
  vec_t        vecs[12];

  pipeline_hazard_ctrl #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start),
    .imem_ready(imem_ready),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_hold(ex_hold),
    .md_done(md_done),
    .stall_count(stall_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic mr,
                             input logic [4:0] ert, input logic br,
                             input logic md, input logic imr);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
    v.ert = ert; v.br = br; v.md = md; v.imr = imr;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %b expected %b (pc,ifw,iff,idf,hold,done)", name, act, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver: drive one cycle of inputs after negedge, compare outputs, track stalls.
  task automatic apply(input string name, input logic rst, input in_t v, input logic [5:0] exp);
    @(negedge clk);
    reset           = rst;
    id_rs           = v.rs;
    id_rt           = v.rt;
    id_uses_rs      = v.urs;
    id_uses_rt      = v.urt;
    ex_mem_read     = v.mr;
    ex_rt           = v.ert;
    ex_branch_taken = v.br;
    ex_md_start     = v.md;
    imem_ready      = v.imr;
    #1;
    check6(name, {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, md_done}, exp);
    if (rst) exp_stalls = 32'h0;
    else if (!exp[5]) exp_stalls = exp_stalls + 32'h1;
  endtask

  task automatic check_stall_count(input string name);
    @(posedge clk);
    #1;
`ifdef HAZARD_STALL_CNT_EN
    check32(name, stall_count, exp_stalls);
`else
    check32(name, stall_count, 32'h0);
`endif
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    exp_stalls    = 32'h0;

    // Single-cycle vectors, each starting and ending in RUN
    vecs[0]  = '{mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 1), O_DEF};   // idle
    vecs[1]  = '{mk(5'd5, 5'd9, 1, 1, 1, 5'd5, 0, 0, 1), O_LU};    // rs load-use
    vecs[2]  = '{mk(5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 1), O_LU};    // rt load-use
    vecs[3]  = '{mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 1), O_DEF};   // ex_rt=0 never hazards
    vecs[4]  = '{mk(5'd5, 5'd9, 0, 1, 1, 5'd5, 0, 0, 1), O_DEF};   // rs match but unused
    vecs[5]  = '{mk(5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 0, 1), O_DEF};   // rt match but unused
    vecs[6]  = '{mk(5'd5, 5'd9, 1, 1, 0, 5'd5, 0, 0, 1), O_DEF};   // not a load
    vecs[7]  = '{mk(5'd5, 5'd9, 1, 1, 1, 5'd5, 1, 0, 1), O_BR};    // branch beats load-use
    vecs[8]  = '{mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 1, 1), O_BR};    // branch beats md_start
    vecs[9]  = '{mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0, 0), O_BR};    // branch beats fetch wait
    vecs[10] = '{mk(5'd5, 5'd9, 1, 1, 1, 5'd5, 0, 0, 0), O_LU};    // load-use beats fetch wait
    vecs[11] = '{mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0), O_IMW};   // fetch wait alone

    // Reset block
    apply("reset_0", 1'b1, idle(), O_RST);
    apply("reset_1", 1'b1, idle(), O_RST);
    check_stall_count("stall_count_after_reset");

    // Table-driven single-cycle checks
    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec_%0d", i), 1'b0, vecs[i].in, vecs[i].exp);
    end

    // Load-use: one bubble, then clears when the load has moved on
    apply("lu_stall", 1'b0, mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1), O_LU);
    apply("lu_clear", 1'b0, mk(5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 1), O_DEF);
    apply("lu_rt0",   1'b0, mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 1), O_DEF);

    // Mul/div: hold cycles 0-2, done in 3; branch and load-use ignored while busy
    apply("md_c0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 1), O_MDH);
    apply("md_c1_branch_ignored", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0, 1), O_MDH);
    apply("md_c2_lu_ignored", 1'b0, mk(5'd5, 5'd2, 1, 1, 1, 5'd5, 0, 0, 0), O_MDH);
    // md_start held high into the done cycle is not sampled there
    apply("md_c3_done", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 1), O_DONE);
    // Back-to-back: the next start is taken in the following RUN cycle
    apply("md2_c0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 1), O_MDH);
    apply("md2_c1", 1'b0, idle(), O_MDH);
    apply("md2_c2", 1'b0, idle(), O_MDH);
    apply("md2_c3_done", 1'b0, idle(), O_DONE);
    apply("md2_after", 1'b0, idle(), O_DEF);

    // Fetch wait for two cycles, then normal
    apply("imem_wait_0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0), O_IMW);
    apply("imem_wait_1", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0), O_IMW);
    apply("imem_back",   1'b0, idle(), O_DEF);
    check_stall_count("stall_count_mid");

    // Reset held 3 cycles in the middle of a mul/div op
    apply("mdr_c0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 1), O_MDH);
    apply("mdr_c1", 1'b0, idle(), O_MDH);
    apply("mdr_reset_0", 1'b1, idle(), O_RST);
    apply("mdr_reset_1_no_done", 1'b1, idle(), O_RST);
    apply("mdr_reset_2", 1'b1, idle(), O_RST);
    apply("mdr_release", 1'b0, idle(), O_DEF);
    apply("mdr_release_1", 1'b0, idle(), O_DEF);

    // Canonical stall sequence: 1 load-use + 3 mul/div hold + 2 fetch waits = 6
    apply("seq_lu", 1'b0, mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1), O_LU);
    apply("seq_md0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 1), O_MDH);
    apply("seq_md1", 1'b0, idle(), O_MDH);
    apply("seq_md2", 1'b0, idle(), O_MDH);
    apply("seq_md3", 1'b0, idle(), O_DONE);
    apply("seq_imw0", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0), O_IMW);
    apply("seq_imw1", 1'b0, mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0), O_IMW);
    check_stall_count("stall_count_seq");
`ifdef HAZARD_STALL_CNT_EN
    check32("stall_count_seq_is_6", stall_count, 32'd6);
`else
    check32("stall_count_tied_0", stall_count, 32'd0);
`endif

    // Report
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
